decode_rf: RTL and testbench

Register-read (decode) stage for the Y86-64 processor. It is the reader side of the register file that write-back updates. The block owns the 15-entry register file and its two write ports, which are driven by write-back. Each cycle it accepts one fetched instruction through a valid/ready handshake. It derives srcA/srcB/dstE/dstM from icode, reads operands with same-cycle write bypass, and presents a registered decode bundle to execute.

---
 rtl/decode_rf.sv | 240 ++++++++++++++++++++++++
 tb/tb_decode_rf.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_rf.sv
// Y86-64 decode stage: owns the register file written by write-back, derives source and
// destination register ids from icode, reads operands with write bypass and registers the bundle.
module decode_rf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned NREG   = 15
) (
  input  logic              clk,
  input  logic              rst,
  // Fetch side
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [3:0]        in_rA,
  input  logic [3:0]        in_rB,
  input  logic [DATA_W-1:0] in_valC,
  input  logic [DATA_W-1:0] in_valP,
  // Write-back ports
  input  logic [3:0]        w_dstE,
  input  logic [DATA_W-1:0] w_valE,
  input  logic [3:0]        w_dstM,
  input  logic [DATA_W-1:0] w_valM,
  // Execute side
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [3:0]        out_srcA,
  output logic [3:0]        out_srcB,
  output logic [3:0]        out_dstE,
  output logic [3:0]        out_dstM,
  output logic [DATA_W-1:0] out_valA,
  output logic [DATA_W-1:0] out_valB,
  output logic [DATA_W-1:0] out_valC,
  output logic              out_err
);

  localparam logic [3:0] RegNone = 4'hF;
  localparam logic [3:0] RegRsp  = 4'h4;

  localparam logic [3:0] IHalt   = 4'h0;
  localparam logic [3:0] INop    = 4'h1;
  localparam logic [3:0] IRrmov  = 4'h2;
  localparam logic [3:0] IIrmov  = 4'h3;
  localparam logic [3:0] IRmmov  = 4'h4;
  localparam logic [3:0] IMrmov  = 4'h5;
  localparam logic [3:0] IOp     = 4'h6;
  localparam logic [3:0] IJxx    = 4'h7;
  localparam logic [3:0] ICall   = 4'h8;
  localparam logic [3:0] IRet    = 4'h9;
  localparam logic [3:0] IPush   = 4'hA;
  localparam logic [3:0] IPop    = 4'hB;

  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        src_a;
    logic [3:0]        src_b;
    logic [3:0]        dst_e;
    logic [3:0]        dst_m;
    logic [DATA_W-1:0] val_a;
    logic [DATA_W-1:0] val_b;
    logic [DATA_W-1:0] val_c;
    logic              err;
  } bundle_t;

  localparam bundle_t BundleRst = '{
    icode: 4'h0, ifun: 4'h0,
    src_a: RegNone, src_b: RegNone, dst_e: RegNone, dst_m: RegNone,
    val_a: '0, val_b: '0, val_c: '0, err: 1'b0
  };

  // ---------------------------------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------------------------------
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];

  // Id 0xF never matches an index, so writes to "none" fall out naturally; M has priority.
  always_comb begin
    for (int unsigned i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
      if (w_dstM == 4'(i)) begin
        rf_d[i] = w_valM;
      end else if (w_dstE == 4'(i)) begin
        rf_d[i] = w_valE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Register id derivation
  // ---------------------------------------------------------------------------------------------
  logic [3:0] src_a;
  logic [3:0] src_b;
  logic [3:0] dst_e;
  logic [3:0] dst_m;

  always_comb begin
    src_a = RegNone;
    unique case (in_icode)
      IRrmov, IRmmov, IOp, IPush: src_a = in_rA;
      IRet, IPop:                 src_a = RegRsp;
      default:                    src_a = RegNone;
    endcase
  end

  always_comb begin
    src_b = RegNone;
    unique case (in_icode)
      IRmmov, IMrmov, IOp:     src_b = in_rB;
      ICall, IRet, IPush, IPop: src_b = RegRsp;
      default:                 src_b = RegNone;
    endcase
  end

  // cmov shares dst_e = rB with rrmovq; the condition is resolved in execute.
  always_comb begin
    dst_e = RegNone;
    unique case (in_icode)
      IRrmov, IIrmov, IOp:      dst_e = in_rB;
      ICall, IRet, IPush, IPop: dst_e = RegRsp;
      default:                  dst_e = RegNone;
    endcase
  end

  always_comb begin
    dst_m = RegNone;
    unique case (in_icode)
      IMrmov, IPop: dst_m = in_rA;
      default:      dst_m = RegNone;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Operand read with same-cycle write-back bypass
  // ---------------------------------------------------------------------------------------------
  logic [3:0]        rd_id  [2];
  logic [DATA_W-1:0] rd_val [2];

  assign rd_id[0] = src_a;
  assign rd_id[1] = src_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = '0;
      if (rd_id[p] != RegNone) begin
        if (rd_id[p] == w_dstM) begin
          rd_val[p] = w_valM;
        end else if (rd_id[p] == w_dstE) begin
          rd_val[p] = w_valE;
        end else begin
          for (int unsigned i = 0; i < NREG; i++) begin
            if (rd_id[p] == 4'(i)) begin
              rd_val[p] = rf_q[i];
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Output bundle register and handshake
  // ---------------------------------------------------------------------------------------------
  bundle_t bundle_new;
  bundle_t bundle_d;
  bundle_t bundle_q;
  logic    out_valid_d;
  logic    out_valid_q;
  logic    capture;

  // Invalid icodes resolve to all-0xF ids, so their operand reads are already zero.
  always_comb begin
    bundle_new       = BundleRst;
    bundle_new.icode = in_icode;
    bundle_new.ifun  = in_ifun;
    bundle_new.src_a = src_a;
    bundle_new.src_b = src_b;
    bundle_new.dst_e = dst_e;
    bundle_new.dst_m = dst_m;
    bundle_new.val_a = (in_icode == IJxx || in_icode == ICall) ? in_valP : rd_val[0];
    bundle_new.val_b = rd_val[1];
    bundle_new.val_c = in_valC;
    bundle_new.err   = (in_icode > IPop);
  end

  assign in_ready = !out_valid_q || out_ready;
  assign capture  = in_valid && in_ready;

  always_comb begin
    bundle_d    = bundle_q;
    out_valid_d = out_valid_q;
    if (capture) begin
      bundle_d    = bundle_new;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bundle_q    <= BundleRst;
      out_valid_q <= 1'b0;
    end else begin
      bundle_q    <= bundle_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_icode = bundle_q.icode;
  assign out_ifun  = bundle_q.ifun;
  assign out_srcA  = bundle_q.src_a;
  assign out_srcB  = bundle_q.src_b;
  assign out_dstE  = bundle_q.dst_e;
  assign out_dstM  = bundle_q.dst_m;
  assign out_valA  = bundle_q.val_a;
  assign out_valB  = bundle_q.val_b;
  assign out_valC  = bundle_q.val_c;
  assign out_err   = bundle_q.err;

  // Halt and nop need no special handling: they fall through to all-0xF ids.
  logic unused_icodes;
  assign unused_icodes = ^{IHalt, INop};

endmodule

// File: tb/tb_decode_rf.sv
// Testbench for decode_rf: decode table, hand-written pipeline sequences and randomized
// traffic checked against a behavioural model of the register file and output register.
module tb_decode_rf;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_icode, in_ifun, in_rA, in_rB;
  logic [63:0] in_valC, in_valP;
  logic [3:0]  w_dstE, w_dstM;
  logic [63:0] w_valE, w_valM;
  logic        out_valid, out_ready;
  logic [3:0]  out_icode, out_ifun, out_srcA, out_srcB, out_dstE, out_dstM;
  logic [63:0] out_valA, out_valB, out_valC;
  logic        out_err;

  always #5 clk = ~clk;

  decode_rf #(.DATA_W(64), .NREG(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun), .in_rA(in_rA), .in_rB(in_rB),
    .in_valC(in_valC), .in_valP(in_valP),
    .w_dstE(w_dstE), .w_valE(w_valE), .w_dstM(w_dstM), .w_valM(w_valM),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_icode(out_icode), .out_ifun(out_ifun),
    .out_srcA(out_srcA), .out_srcB(out_srcB), .out_dstE(out_dstE), .out_dstM(out_dstM),
    .out_valA(out_valA), .out_valB(out_valB), .out_valC(out_valC), .out_err(out_err)
  );

  typedef struct {
    logic [3:0]  icode, ifun, src_a, src_b, dst_e, dst_m;
    logic [63:0] val_a, val_b, val_c;
    logic        err;
  } bun_t;

  typedef struct {
    logic [3:0]  icode, rA, rB;
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] val_a, val_b;
    logic        err;
  } vec_t;

  // Reference state: architectural registers, output-stage validity and contents.
  logic [63:0] m_rf [16];
  logic        m_valid;
  bun_t        m_out;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bun_t rst_bundle();
    bun_t b;
    b.icode = 4'h0; b.ifun = 4'h0;
    b.src_a = 4'hF; b.src_b = 4'hF; b.dst_e = 4'hF; b.dst_m = 4'hF;
    b.val_a = 64'h0; b.val_b = 64'h0; b.val_c = 64'h0; b.err = 1'b0;
    return b;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] s);
    if (s == 4'hF) return 64'h0;
    if (s == w_dstM) return w_valM;
    if (s == w_dstE) return w_valE;
    return m_rf[s];
  endfunction

  function automatic bun_t m_decode();
    bun_t b;
    b.icode = in_icode;
    b.ifun  = in_ifun;
    b.src_a = (in_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? in_rA :
              (in_icode inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    b.src_b = (in_icode inside {4'h4, 4'h5, 4'h6}) ? in_rB :
              (in_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    b.dst_e = (in_icode inside {4'h2, 4'h3, 4'h6}) ? in_rB :
              (in_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    b.dst_m = (in_icode inside {4'h5, 4'hB}) ? in_rA : 4'hF;
    b.val_a = (in_icode inside {4'h7, 4'h8}) ? in_valP : m_read(b.src_a);
    b.val_b = m_read(b.src_b);
    b.val_c = in_valC;
    b.err   = (in_icode > 4'hB);
    return b;
  endfunction

  task automatic compare_all();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_icode", 64'(out_icode), 64'(m_out.icode));
    check("out_ifun",  64'(out_ifun),  64'(m_out.ifun));
    check("out_srcA",  64'(out_srcA),  64'(m_out.src_a));
    check("out_srcB",  64'(out_srcB),  64'(m_out.src_b));
    check("out_dstE",  64'(out_dstE),  64'(m_out.dst_e));
    check("out_dstM",  64'(out_dstM),  64'(m_out.dst_m));
    check("out_valA",  out_valA, m_out.val_a);
    check("out_valB",  out_valB, m_out.val_b);
    check("out_valC",  out_valC, m_out.val_c);
    check("out_err",   64'(out_err),   64'(m_out.err));
  endtask

  // One clock: predict from current inputs, advance, then compare everything.
  task automatic tick();
    bun_t nb;
    logic nv;
    #1;
    if (!rst) check("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
    if (rst) begin
      nv = 1'b0;
      nb = rst_bundle();
      for (int i = 0; i < 16; i++) m_rf[i] = 64'h0;
    end else begin
      nv = m_valid;
      nb = m_out;
      if (in_valid && (!m_valid || out_ready)) begin
        nb = m_decode();
        nv = 1'b1;
      end else if (out_ready) begin
        nv = 1'b0;
      end
      if (w_dstE != 4'hF) m_rf[w_dstE] = w_valE;
      if (w_dstM != 4'hF) m_rf[w_dstM] = w_valM;
    end
    @(posedge clk);
    #1;
    m_valid = nv;
    m_out   = nb;
    compare_all();
  endtask

  task automatic set_in(input logic v, input logic [3:0] ic, input logic [3:0] rA,
                        input logic [3:0] rB, input logic [63:0] vc, input logic [63:0] vp);
    in_valid = v; in_icode = ic; in_ifun = 4'h0; in_rA = rA; in_rB = rB;
    in_valC = vc; in_valP = vp;
  endtask

  task automatic set_wb(input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm);
    w_dstE = de; w_valE = ve; w_dstM = dm; w_valM = vm;
  endtask

  vec_t vecs [14];
  int   nvalid;
  logic [3:0] b2b [8];

  initial begin
    vecs[0]  = '{4'h0, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    1'b0};
    vecs[1]  = '{4'h1, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    1'b0};
    vecs[2]  = '{4'h2, 4'h1, 4'h2, 4'h1, 4'hF, 4'h2, 4'hF, 64'h1001, 64'h0,    1'b0};
    vecs[3]  = '{4'h3, 4'hF, 4'h2, 4'hF, 4'hF, 4'h2, 4'hF, 64'h0,    64'h0,    1'b0};
    vecs[4]  = '{4'h4, 4'h1, 4'h2, 4'h1, 4'h2, 4'hF, 4'hF, 64'h1001, 64'h1002, 1'b0};
    vecs[5]  = '{4'h5, 4'h1, 4'h2, 4'hF, 4'h2, 4'hF, 4'h1, 64'h0,    64'h1002, 1'b0};
    vecs[6]  = '{4'h6, 4'h1, 4'h2, 4'h1, 4'h2, 4'h2, 4'hF, 64'h1001, 64'h1002, 1'b0};
    vecs[7]  = '{4'h7, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 64'h3000, 64'h0,    1'b0};
    vecs[8]  = '{4'h8, 4'h1, 4'h2, 4'hF, 4'h4, 4'h4, 4'hF, 64'h3000, 64'h1004, 1'b0};
    vecs[9]  = '{4'h9, 4'h1, 4'h2, 4'h4, 4'h4, 4'h4, 4'hF, 64'h1004, 64'h1004, 1'b0};
    vecs[10] = '{4'hA, 4'h1, 4'h2, 4'h1, 4'h4, 4'h4, 4'hF, 64'h1001, 64'h1004, 1'b0};
    vecs[11] = '{4'hB, 4'h1, 4'h2, 4'h4, 4'h4, 4'h4, 4'h1, 64'h1004, 64'h1004, 1'b0};
    vecs[12] = '{4'hC, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    1'b1};
    vecs[13] = '{4'hF, 4'h1, 4'h2, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,    64'h0,    1'b1};
    b2b = '{4'h6, 4'h2, 4'h3, 4'hC, 4'h1, 4'hA, 4'h9, 4'h5};

    for (int i = 0; i < 16; i++) m_rf[i] = 64'h0;
    m_valid = 1'b0;
    m_out   = rst_bundle();

    // Reset
    rst = 1'b1; out_ready = 1'b1;
    set_in(1'b0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_srcA", 64'(out_srcA), 64'hF);
    check("rst_dstM", 64'(out_dstM), 64'hF);
    check("rst_err", 64'(out_err), 64'h0);
    rst = 1'b0;
    #1 check("ready_after_rst", 64'(in_ready), 64'h1);

    // Write r3 = 0x55, then opq r3, r3
    set_wb(4'h3, 64'h55, 4'hF, 64'h0);
    tick();
    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    set_in(1'b1, 4'h6, 4'h3, 4'h3, 64'h0, 64'h0);
    tick();
    check("opq_valid", 64'(out_valid), 64'h1);
    check("opq_valA", out_valA, 64'h55);
    check("opq_valB", out_valB, 64'h55);
    check("opq_dstE", 64'(out_dstE), 64'h3);

    // Same-cycle bypass; M port wins over E port
    set_wb(4'h2, 64'hBB, 4'h2, 64'hAA);
    set_in(1'b1, 4'h2, 4'h2, 4'h7, 64'h0, 64'h0);
    tick();
    check("bypass_valA", out_valA, 64'hAA);
    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    tick();
    check("array_r2", out_valA, 64'hAA);

    // Stack ops with rsp = 0x100
    set_in(1'b0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    set_wb(4'h4, 64'h100, 4'hF, 64'h0);
    tick();
    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    set_in(1'b1, 4'hB, 4'h4, 4'hF, 64'h0, 64'h9);
    tick();
    check("popq_srcA", 64'(out_srcA), 64'h4);
    check("popq_srcB", 64'(out_srcB), 64'h4);
    check("popq_dstE", 64'(out_dstE), 64'h4);
    check("popq_dstM", 64'(out_dstM), 64'h4);
    check("popq_valA", out_valA, 64'h100);
    check("popq_valB", out_valB, 64'h100);
    set_in(1'b1, 4'h8, 4'hF, 4'hF, 64'h500, 64'h20);
    tick();
    check("call_valA", out_valA, 64'h20);
    check("call_srcA", 64'(out_srcA), 64'hF);

    // Stall for 3 cycles with a pending input
    out_ready = 1'b0;
    set_in(1'b1, 4'h6, 4'h1, 4'h2, 64'h77, 64'h88);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_in_ready", 64'(in_ready), 64'h0);
      check("stall_icode", 64'(out_icode), 64'h8);
      check("stall_valA", out_valA, 64'h20);
      check("stall_valB", out_valB, 64'h100);
      check("stall_valC", out_valC, 64'h500);
    end
    out_ready = 1'b1;
    tick();
    check("unstall_icode", 64'(out_icode), 64'h6);
    check("unstall_valC", out_valC, 64'h77);
    set_in(1'b0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    tick();
    check("unstall_no_dup", 64'(out_valid), 64'h0);

    // Back-to-back stream including an invalid icode
    nvalid = 0;
    for (int i = 0; i < 8; i++) begin
      set_in(1'b1, b2b[i], 4'h3, 4'h2, 64'(i), 64'(i + 100));
      tick();
      if (out_valid) nvalid++;
      if (b2b[i] == 4'hC) begin
        check("inv_err", 64'(out_err), 64'h1);
        check("inv_srcA", 64'(out_srcA), 64'hF);
        check("inv_srcB", 64'(out_srcB), 64'hF);
        check("inv_dstE", 64'(out_dstE), 64'hF);
        check("inv_dstM", 64'(out_dstM), 64'hF);
        check("inv_valA", out_valA, 64'h0);
        check("inv_valB", out_valB, 64'h0);
      end
    end
    check("b2b_valid_count", 64'(nvalid), 64'd8);
    set_in(1'b0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    tick();

    // Reset while stalled with a valid bundle; write during reset is dropped
    set_in(1'b1, 4'h6, 4'h3, 4'h4, 64'h1, 64'h2);
    tick();
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    set_wb(4'h5, 64'h99, 4'hF, 64'h0);
    tick();
    check("rst_stall_valid", 64'(out_valid), 64'h0);
    check("rst_stall_valA", out_valA, 64'h0);
    check("rst_stall_srcA", 64'(out_srcA), 64'hF);
    rst = 1'b0;
    out_ready = 1'b1;
    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    set_in(1'b1, 4'h6, 4'h5, 4'h4, 64'h0, 64'h0);
    tick();
    check("cleared_r5", out_valA, 64'h0);
    check("cleared_rsp", out_valB, 64'h0);

    // Decode table against registers preloaded with 0x1000 + id
    set_in(1'b0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
    for (int i = 0; i < 15; i++) begin
      set_wb(4'(i), 64'h1000 + 64'(i), 4'hF, 64'h0);
      tick();
    end
    set_wb(4'hF, 64'h0, 4'hF, 64'h0);
    foreach (vecs[k]) begin
      set_in(1'b1, vecs[k].icode, vecs[k].rA, vecs[k].rB, 64'hC0 + 64'(k), 64'h3000);
      tick();
      check("tbl_srcA", 64'(out_srcA), 64'(vecs[k].src_a));
      check("tbl_srcB", 64'(out_srcB), 64'(vecs[k].src_b));
      check("tbl_dstE", 64'(out_dstE), 64'(vecs[k].dst_e));
      check("tbl_dstM", 64'(out_dstM), 64'(vecs[k].dst_m));
      check("tbl_valA", out_valA, vecs[k].val_a);
      check("tbl_valB", out_valB, vecs[k].val_b);
      check("tbl_err",  64'(out_err), 64'(vecs[k].err));
    end

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_in(1'(($urandom_range(0, 2)) != 0), 4'($urandom), 4'($urandom), 4'($urandom),
             {$urandom, $urandom}, {$urandom, $urandom});
      in_ifun = 4'($urandom);
      set_wb(4'($urandom), {$urandom, $urandom}, 4'($urandom), {$urandom, $urandom});
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
